fifo_drain_ctrl: RTL and testbench

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

---
 rtl/fifo_drain_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Drains a synchronous FIFO into a 2-entry output buffer with valid/ready handoff.
// Optional running XOR checksum when FIFO_DRAIN_CSUM_EN is defined.
// state | meaning
// IDLE  | waiting for go
// RUN   | issuing reads
// FLUSH | no new reads, draining in-flight and buffered words
// DONE  | burst finished, waiting for go to drop
module fifo_drain_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              go,
  input  logic [CNT_W-1:0]  max_words,
  input  logic              EMPTY,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              RD,
  output logic              EN,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  words_done,
  output logic              busy,
  output logic [DATA_W-1:0] csum
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              pending_q;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
  logic [CNT_W-1:0]  max_q, rd_cnt_q, words_q;
  logic              start, xfer, limit_hit;
  logic [2:0]        inflight;

  assign start     = (state_q == S_IDLE) & go;
  assign xfer      = out_valid & out_ready;
  assign limit_hit = (max_q != '0) & (rd_cnt_q == max_q);
  assign inflight  = {1'b0, occ_q} + {2'b00, pending_q};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (!go || limit_hit) state_d = S_FLUSH;
      S_FLUSH: if (!pending_q && occ_q == 2'd0) state_d = S_DONE;
      S_DONE:  if (!go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    RD   = Rst & (state_q == S_RUN) & ~EMPTY & (inflight < 3'd2) & ~limit_hit;
    busy = (state_q == S_RUN) | (state_q == S_FLUSH);
    EN   = Rst;
  end

  // Buffer update: capture of the word read last cycle and/or pop of the head.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({pending_q, xfer})
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_data;
        else               buf1_d = fifo_data;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pending_q <= 1'b0;
      occ_q     <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      max_q     <= '0;
      rd_cnt_q  <= '0;
      words_q   <= '0;
    end else begin
      pending_q <= RD;
      occ_q     <= occ_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      if (start) begin
        max_q    <= max_words;
        rd_cnt_q <= '0;
        words_q  <= '0;
      end else begin
        if (RD)   rd_cnt_q <= rd_cnt_q + 1'b1;
        if (xfer) words_q  <= words_q + 1'b1;
      end
    end
  end

  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = buf0_q;
  assign words_done = words_q;

`ifdef FIFO_DRAIN_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)      csum_q <= '0;
    else if (start) csum_q <= '0;
    else if (xfer)  csum_q <= csum_q ^ out_data;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: behavioural FIFO feeds the DUT, expected
// words are queued at each read and compared when the DUT hands them downstream.
module tb_fifo_drain_ctrl;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              go;
  logic [CNT_W-1:0]  max_words;
  logic              EMPTY;
  logic [DATA_W-1:0] fifo_data;
  logic              RD;
  logic              EN;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  words_done;
  logic              busy;
  logic [DATA_W-1:0] csum;

  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] sb_csum;
  int fifo_n = 0;
  int rd_pulses = 0;
  int xfers = 0;
  int total = 0;
  int bad = 0;

  fifo_drain_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .go(go), .max_words(max_words), .EMPTY(EMPTY),
    .fifo_data(fifo_data), .RD(RD), .EN(EN), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .words_done(words_done),
    .busy(busy), .csum(csum)
  );

  always #5 Clk = ~Clk;

  assign EMPTY = (fifo_n == 0);

  // Behavioural FIFO: data appears the cycle after the read edge.
  always @(posedge Clk) begin
    if (RD && fq.size() > 0) begin
      fifo_data <= fq[0];
      exp_q.push_back(fq[0]);
      void'(fq.pop_front());
      rd_pulses++;
    end
    fifo_n <= fq.size();
  end

  always @(negedge Clk) begin
    if (Rst && out_valid && out_ready) begin
      logic [DATA_W-1:0] e;
      total++;
      xfers++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got out_data=%h, expected no transfer", out_data);
      end else begin
        e = exp_q.pop_front();
        sb_csum = sb_csum ^ e;
        if (out_data !== e) begin
          bad++;
          $display("FAIL sb_data: got %h expected %h", out_data, e);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] exp_csum();
`ifdef FIFO_DRAIN_CSUM_EN
    return sb_csum;
`else
    return '0;
`endif
  endfunction

  task automatic drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(posedge Clk); #1;
      if (fq.size() == 0 && exp_q.size() == 0 && !out_valid && !RD) return;
    end
    total++; bad++;
    $display("FAIL %s_drain_timeout: fifo=%0d queued=%0d expected both 0", tag, fq.size(), exp_q.size());
  endtask

  task automatic wait_busy_low(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(posedge Clk); #1;
      if (!busy) return;
    end
    total++; bad++;
    $display("FAIL %s_busy_timeout: busy=%b expected 0", tag, busy);
  endtask

  task automatic end_burst();
    go = 1'b0;
    wait_busy_low(20, "end");
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; go = 1'b0; out_ready = 1'b0; max_words = '0; sb_csum = '0;
    fq.push_back(16'h000A);
    fq.push_back(16'h000B);
    @(posedge Clk); #1;
    total += 6;
    if (EN !== 1'b0)        begin bad++; $display("FAIL rst_en: got %b expected 0", EN); end
    if (RD !== 1'b0)        begin bad++; $display("FAIL rst_rd: got %b expected 0", RD); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (words_done !== '0)  begin bad++; $display("FAIL rst_words: got %h expected 0", words_done); end
    if (csum !== '0)        begin bad++; $display("FAIL rst_csum: got %h expected 0", csum); end
    Rst = 1'b1; go = 1'b1; out_ready = 1'b1;
    #2;
    total += 2;
    if (EN !== 1'b1) begin bad++; $display("FAIL rel_en: got %b expected 1", EN); end
    if (RD !== 1'b0) begin bad++; $display("FAIL rel_rd_early: got %b expected 0", RD); end
    @(posedge Clk); #1;
    total += 2;
    if (RD !== 1'b1)   begin bad++; $display("FAIL rel_rd_first: got %b expected 1", RD); end
    if (busy !== 1'b1) begin bad++; $display("FAIL rel_busy: got %b expected 1", busy); end
    drain(50, "rel");
    total++;
    if (words_done !== 4'd2) begin bad++; $display("FAIL rel_words: got %0d expected 2", words_done); end
    end_burst();
  endtask

  task automatic test_basic();
    int r0, x0;
    r0 = rd_pulses; x0 = xfers; sb_csum = '0;
    fq.push_back(16'h0011); fq.push_back(16'h0022); fq.push_back(16'h0033);
    max_words = '0; out_ready = 1'b1;
    @(posedge Clk); #1;
    go = 1'b1;
    drain(50, "basic");
    total += 6;
    if (words_done !== 4'd3)     begin bad++; $display("FAIL basic_words: got %0d expected 3", words_done); end
    if (csum !== 16'h0000)       begin bad++; $display("FAIL basic_csum: got %h expected 0000", csum); end
    if (xfers - x0 != 3)         begin bad++; $display("FAIL basic_xfers: got %0d expected 3", xfers - x0); end
    if (rd_pulses - r0 != 3)     begin bad++; $display("FAIL basic_rds: got %0d expected 3", rd_pulses - r0); end
    if (RD !== 1'b0)             begin bad++; $display("FAIL basic_rd_empty: got %b expected 0", RD); end
    if (busy !== 1'b1)           begin bad++; $display("FAIL basic_run_hold: got %b expected 1", busy); end
    end_burst();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b expected 0", busy); end
  endtask

  task automatic test_limit();
    int r0, x0;
    r0 = rd_pulses; x0 = xfers; sb_csum = '0;
    for (int i = 0; i < 8; i++) fq.push_back(DATA_W'(16'h00A0 + i));
    max_words = 4'd5; out_ready = 1'b1;
    @(posedge Clk); #1;
    go = 1'b1;
    @(posedge Clk); #1;
    wait_busy_low(60, "limit");
    repeat (3) @(posedge Clk);
    #1;
    total += 6;
    if (rd_pulses - r0 != 5)  begin bad++; $display("FAIL limit_rds: got %0d expected 5", rd_pulses - r0); end
    if (xfers - x0 != 5)      begin bad++; $display("FAIL limit_xfers: got %0d expected 5", xfers - x0); end
    if (fq.size() != 3)       begin bad++; $display("FAIL limit_left: got %0d expected 3", fq.size()); end
    if (words_done !== 4'd5)  begin bad++; $display("FAIL limit_words: got %0d expected 5", words_done); end
    if (busy !== 1'b0)        begin bad++; $display("FAIL limit_done: got %b expected 0", busy); end
    if (csum !== exp_csum())  begin bad++; $display("FAIL limit_csum: got %h expected %h", csum, exp_csum()); end
    end_burst();
    fq.delete();
    max_words = '0;
    @(posedge Clk); #1;
  endtask

  task automatic test_backpressure();
    int r0, x0;
    logic              seen;
    logic [DATA_W-1:0] held;
    r0 = rd_pulses; x0 = xfers; sb_csum = '0; seen = 1'b0; held = '0;
    for (int i = 0; i < 6; i++) fq.push_back(DATA_W'(16'h0050 + i));
    out_ready = 1'b0;
    @(posedge Clk); #1;
    go = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1; held = out_data;
        end else begin
          total++;
          if (out_data !== held) begin bad++; $display("FAIL bp_stable: got %h expected %h", out_data, held); end
        end
      end
    end
    total += 3;
    if (rd_pulses - r0 > 2)  begin bad++; $display("FAIL bp_rds: got %0d expected at most 2", rd_pulses - r0); end
    if (out_valid !== 1'b1)  begin bad++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    if (held !== 16'h0050)   begin bad++; $display("FAIL bp_head: got %h expected 0050", held); end
    out_ready = 1'b1;
    drain(80, "bp");
    total += 3;
    if (xfers - x0 != 6)     begin bad++; $display("FAIL bp_xfers: got %0d expected 6", xfers - x0); end
    if (words_done !== 4'd6) begin bad++; $display("FAIL bp_words: got %0d expected 6", words_done); end
    if (csum !== exp_csum()) begin bad++; $display("FAIL bp_csum: got %h expected %h", csum, exp_csum()); end
    end_burst();
  endtask

  task automatic test_go_drop();
    int r0, x0;
    r0 = rd_pulses; x0 = xfers; sb_csum = '0;
    for (int i = 0; i < 4; i++) fq.push_back(DATA_W'(16'h0070 + i));
    out_ready = 1'b1;
    @(posedge Clk); #1;
    go = 1'b1;
    for (int c = 0; c < 20 && !RD; c++) begin
      @(posedge Clk); #1;
    end
    total += 2;
    if (RD !== 1'b1)   begin bad++; $display("FAIL drop_rd_seen: got %b expected 1", RD); end
    if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy: got %b expected 1", busy); end
    go = 1'b0;
    wait_busy_low(20, "drop");
    repeat (2) @(posedge Clk);
    #1;
    total += 5;
    if (rd_pulses - r0 != 1) begin bad++; $display("FAIL drop_rds: got %0d expected 1", rd_pulses - r0); end
    if (xfers - x0 != 1)     begin bad++; $display("FAIL drop_xfers: got %0d expected 1", xfers - x0); end
    if (fq.size() != 3)      begin bad++; $display("FAIL drop_left: got %0d expected 3", fq.size()); end
    if (words_done !== 4'd1) begin bad++; $display("FAIL drop_words: got %0d expected 1", words_done); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL drop_busy_low: got %b expected 0", busy); end
    fq.delete();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    int x0;
    x0 = xfers; sb_csum = '0;
    for (int i = 0; i < 6; i++) fq.push_back(DATA_W'(16'h0090 + i));
    out_ready = 1'b1;
    @(posedge Clk); #1;
    go = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    out_ready = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    total += 2;
    if (out_valid !== 1'b1)                     begin bad++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
    if (words_done !== CNT_W'(xfers - x0))      begin bad++; $display("FAIL mid_pre_words: got %0d expected %0d", words_done, xfers - x0); end
    #2;
    Rst = 1'b0;
    #1;
    total += 6;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
    if (RD !== 1'b0)        begin bad++; $display("FAIL mid_rd: got %b expected 0", RD); end
    if (EN !== 1'b0)        begin bad++; $display("FAIL mid_en: got %b expected 0", EN); end
    if (words_done !== '0)  begin bad++; $display("FAIL mid_words: got %0d expected 0", words_done); end
    if (csum !== '0)        begin bad++; $display("FAIL mid_csum: got %h expected 0", csum); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
    exp_q.delete();
    fq.delete();
    go = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic test_wrap();
    int r0, x0;
    r0 = rd_pulses; x0 = xfers; sb_csum = '0;
    for (int i = 0; i < 17; i++) fq.push_back(DATA_W'(16'h0100 + 3 * i));
    out_ready = 1'b1; max_words = '0;
    @(posedge Clk); #1;
    go = 1'b1;
    drain(200, "wrap");
    total += 4;
    if (words_done !== 4'd1)  begin bad++; $display("FAIL wrap_words: got %0d expected 1", words_done); end
    if (xfers - x0 != 17)     begin bad++; $display("FAIL wrap_xfers: got %0d expected 17", xfers - x0); end
    if (rd_pulses - r0 != 17) begin bad++; $display("FAIL wrap_rds: got %0d expected 17", rd_pulses - r0); end
    if (csum !== exp_csum())  begin bad++; $display("FAIL wrap_csum: got %h expected %h", csum, exp_csum()); end
    end_burst();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit();
    test_backpressure();
    test_go_drop();
    test_reset_mid();
    test_wrap();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d queued expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
